// File: rtl/matrix_pkg.sv
// Shared matrix register-file types: write-port beat layout and arbiter states.
package matrix_pkg;

    localparam int unsigned RLEN   = 128;
    localparam int unsigned N_REGS = 8;
    localparam int unsigned N_ROWS = 4;

    localparam int unsigned REG_AW = $clog2(N_REGS);
    localparam int unsigned ROW_AW = $clog2(N_ROWS);

    typedef struct packed {
        logic [REG_AW-1:0] waddr;
        logic [ROW_AW-1:0] wrowaddr;
        logic [RLEN-1:0]   wdata;
        logic              we;
        logic              wlast;
    } wport_beat_t;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } wport_arb_state_e;

endpackage

// File: rtl/matrix_rf_wport_arbiter_if.sv
// Writer-side request bundle plus the shared register-file write port.
interface matrix_rf_wport_arbiter_if #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned RLEN   = matrix_pkg::RLEN,
    parameter int unsigned N_REGS = matrix_pkg::N_REGS,
    parameter int unsigned N_ROWS = matrix_pkg::N_ROWS
);
    localparam int unsigned AW = $clog2(N_REGS);
    localparam int unsigned RW = $clog2(N_ROWS);

    logic [N_REQ-1:0][AW-1:0]   req_waddr_i;
    logic [N_REQ-1:0][RW-1:0]   req_wrowaddr_i;
    logic [N_REQ-1:0][RLEN-1:0] req_wdata_i;
    logic [N_REQ-1:0]           req_we_i;
    logic [N_REQ-1:0]           req_wlast_i;
    logic [N_REQ-1:0]           req_wready_o;

    logic [AW-1:0]              waddr_o;
    logic [RW-1:0]              wrowaddr_o;
    logic [RLEN-1:0]            wdata_o;
    logic                       we_o;
    logic                       wlast_o;
    logic                       wready_i;

    modport slave (
        input  req_waddr_i, req_wrowaddr_i, req_wdata_i, req_we_i, req_wlast_i, wready_i,
        output req_wready_o, waddr_o, wrowaddr_o, wdata_o, we_o, wlast_o
    );

    modport master (
        output req_waddr_i, req_wrowaddr_i, req_wdata_i, req_we_i, req_wlast_i, wready_i,
        input  req_wready_o, waddr_o, wrowaddr_o, wdata_o, we_o, wlast_o
    );

endinterface

// File: rtl/matrix_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module matrix_rr_picker #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IW-1:0]    idx_o,
    output logic             valid_o
);

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int unsigned i);
        int unsigned s;
        s = int'(p) + i;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return IW'(s);
    endfunction

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!valid_o && req_i[wrap_add(ptr_i, i)]) begin
                valid_o = 1'b1;
                idx_o   = wrap_add(ptr_i, i);
            end
        end
        grant_o = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            grant_o[i] = valid_o && (idx_o == IW'(i));
        end
    end

endmodule

// File: rtl/matrix_rf_wport_arbiter.sv
// Burst-locking round-robin arbiter for the matrix register-file write port.
module matrix_rf_wport_arbiter #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned RLEN   = matrix_pkg::RLEN,
    parameter int unsigned N_REGS = matrix_pkg::N_REGS,
    parameter int unsigned N_ROWS = matrix_pkg::N_ROWS
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    matrix_rf_wport_arbiter_if.slave  bus,
    output logic [N_REQ-1:0]          grant_o,
    output logic                      locked_o,
    output logic                      err_o
);
    import matrix_pkg::*;

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned AW = $clog2(N_REGS);
    localparam int unsigned RW = $clog2(N_ROWS);
    localparam int unsigned BW = $clog2(N_ROWS) + 1;

    wport_arb_state_e state_q;
    logic [IW-1:0]    owner_q;
    logic [IW-1:0]    rr_ptr_q;
    logic [BW-1:0]    beat_q;
    logic             err_q;

    logic [N_REQ-1:0] pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;

    logic [IW-1:0]    sel_idx;
    logic [IW-1:0]    nxt_ptr;
    logic             sel_valid;
    logic [N_REQ-1:0] grant;
    logic [AW-1:0]    mux_waddr;
    logic [RW-1:0]    mux_wrowaddr;
    logic [RLEN-1:0]  mux_wdata;
    logic             mux_we;
    logic             mux_wlast;
    logic             accept;
    logic             last_acc;

    matrix_rr_picker #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_picker (
        .req_i   (bus.req_we_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Output gating by rst_ni keeps the port quiet while reset is held, even
    // with requests present, since the picker itself is purely combinational.
    always_comb begin
        sel_idx      = (state_q == ST_LOCKED) ? owner_q : pick_idx;
        sel_valid    = rst_ni && ((state_q == ST_LOCKED) || pick_valid);
        grant        = '0;
        mux_waddr    = '0;
        mux_wrowaddr = '0;
        mux_wdata    = '0;
        mux_we       = 1'b0;
        mux_wlast    = 1'b0;
        if (sel_valid) begin
            if (state_q == ST_LOCKED) begin
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    grant[i] = (owner_q == IW'(i));
                end
            end else begin
                grant = pick_grant;
            end
            mux_waddr    = bus.req_waddr_i[sel_idx];
            mux_wrowaddr = bus.req_wrowaddr_i[sel_idx];
            mux_wdata    = bus.req_wdata_i[sel_idx];
            mux_we       = bus.req_we_i[sel_idx];
            mux_wlast    = bus.req_wlast_i[sel_idx];
        end
    end

    assign accept   = mux_we & bus.wready_i;
    assign last_acc = accept & mux_wlast;
    assign nxt_ptr  = (sel_idx == IW'(N_REQ - 1)) ? '0 : sel_idx + IW'(1);

    assign bus.waddr_o      = mux_waddr;
    assign bus.wrowaddr_o   = mux_wrowaddr;
    assign bus.wdata_o      = mux_wdata;
    assign bus.we_o         = mux_we;
    assign bus.wlast_o      = mux_wlast;
    assign bus.req_wready_o = grant & {N_REQ{bus.wready_i}};

    assign grant_o  = grant;
    assign locked_o = (state_q == ST_LOCKED);
    assign err_o    = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
        end else if (last_acc) begin
            // A single-beat burst granted in IDLE ends here without locking.
            state_q  <= ST_IDLE;
            rr_ptr_q <= nxt_ptr;
            beat_q   <= '0;
            if (beat_q != BW'(N_ROWS - 1)) begin
                err_q <= 1'b1;
            end
        end else begin
            if ((state_q == ST_IDLE) && pick_valid) begin
                state_q <= ST_LOCKED;
                owner_q <= pick_idx;
            end
            if (accept) begin
                beat_q <= beat_q + BW'(1);
                if (beat_q == BW'(N_ROWS - 1)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_rf_wport_arbiter.sv
// Randomized and directed bench for the write-port arbiter against a burst-level model.
module tb_matrix_rf_wport_arbiter;
    import matrix_pkg::*;

    localparam int unsigned NR = 3;
    localparam int unsigned AW = $clog2(N_REGS);
    localparam int unsigned RW = $clog2(N_ROWS);

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic [NR-1:0] grant_o;
    logic          locked_o;
    logic          err_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    matrix_rf_wport_arbiter_if #(
        .N_REQ  (NR),
        .RLEN   (RLEN),
        .N_REGS (N_REGS),
        .N_ROWS (N_ROWS)
    ) bus ();

    matrix_rf_wport_arbiter #(
        .N_REQ  (NR),
        .RLEN   (RLEN),
        .N_REGS (N_REGS),
        .N_ROWS (N_ROWS)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .bus      (bus),
        .grant_o  (grant_o),
        .locked_o (locked_o),
        .err_o    (err_o)
    );

    // Writer agents: each plays one burst of rows 0..last_at, with optional bubbles.
    bit              a_active [NR];
    int              a_sent   [NR];
    int              a_last_at[NR];
    int              a_bubble [NR];
    logic [AW-1:0]   a_reg    [NR];
    logic [RLEN-1:0] a_data   [NR];
    logic            ready_drv = 1'b1;

    // Burst-level model: who owns the port, where the rotation resumes, beats seen.
    int m_owner = -1;
    int m_rr    = 0;
    int m_beats = 0;
    bit m_err   = 1'b0;

    int acc_idx;
    bit acc_last;
    int cyc;
    int ord_q[$];
    int cyc_q[$];

    task automatic check(input string nm, input logic [RLEN-1:0] act, input logic [RLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [RLEN-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit any_active();
        bit a = 1'b0;
        for (int r = 0; r < NR; r++) a |= a_active[r];
        return a;
    endfunction

    task automatic start(input int r, input int rg, input int last_at);
        a_active[r]  = 1'b1;
        a_sent[r]    = 0;
        a_last_at[r] = last_at;
        a_bubble[r]  = 0;
        a_reg[r]     = AW'(rg);
        a_data[r]    = rnd_data();
    endtask

    task automatic clear_agents();
        for (int r = 0; r < NR; r++) begin
            a_active[r] = 1'b0;
            a_sent[r]   = 0;
            a_bubble[r] = 0;
        end
        ready_drv = 1'b1;
    endtask

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            bus.req_we_i[r]       = a_active[r] && (a_bubble[r] == 0);
            bus.req_wlast_i[r]    = a_active[r] && (a_sent[r] == a_last_at[r]);
            bus.req_wrowaddr_i[r] = RW'(a_sent[r]);
            bus.req_waddr_i[r]    = a_reg[r];
            bus.req_wdata_i[r]    = a_data[r];
        end
        bus.wready_i = ready_drv;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_rr    = 0;
        m_beats = 0;
        m_err   = 1'b0;
        cyc     = 0;
        ord_q.delete();
        cyc_q.delete();
    endtask

    task automatic quiet_checks(input string pfx);
        check({pfx, "_grant"}, grant_o, '0);
        check({pfx, "_locked"}, locked_o, '0);
        check({pfx, "_err"}, err_o, '0);
        check({pfx, "_we"}, bus.we_o, '0);
        check({pfx, "_wlast"}, bus.wlast_o, '0);
        check({pfx, "_wdata"}, bus.wdata_o, '0);
        check({pfx, "_waddr"}, bus.waddr_o, '0);
        check({pfx, "_wready"}, bus.req_wready_o, '0);
        check({pfx, "_rrptr"}, dut.rr_ptr_q, '0);
    endtask

    // One cycle: outputs checked against the model, then both advance on the edge.
    task automatic step();
        int          sel;
        wport_beat_t exp_b;
        logic [NR-1:0] exp_g;
        bit          acc;
        bit          lst;
        drive();
        #1;
        sel = -1;
        if (m_owner >= 0) begin
            sel = m_owner;
        end else begin
            for (int j = 0; j < NR; j++) begin
                int k;
                k = (m_rr + j) % NR;
                if (sel < 0 && bus.req_we_i[k]) sel = k;
            end
        end
        exp_g = '0;
        exp_b = '0;
        if (sel >= 0) begin
            exp_g[sel]     = 1'b1;
            exp_b.waddr    = bus.req_waddr_i[sel];
            exp_b.wrowaddr = bus.req_wrowaddr_i[sel];
            exp_b.wdata    = bus.req_wdata_i[sel];
            exp_b.we       = bus.req_we_i[sel];
            exp_b.wlast    = bus.req_wlast_i[sel];
        end
        check("grant", grant_o, exp_g);
        check("locked", locked_o, m_owner >= 0);
        check("err", err_o, m_err);
        check("we_o", bus.we_o, exp_b.we);
        check("wlast_o", bus.wlast_o, exp_b.wlast);
        check("waddr_o", bus.waddr_o, exp_b.waddr);
        check("wrowaddr_o", bus.wrowaddr_o, exp_b.wrowaddr);
        check("wdata_o", bus.wdata_o, exp_b.wdata);
        check("req_wready", bus.req_wready_o, exp_g & {NR{ready_drv}});
        acc = (sel >= 0) && exp_b.we && ready_drv;
        lst = acc && exp_b.wlast;
        @(posedge clk);
        if (acc) begin
            if (lst) begin
                if (m_beats != N_ROWS - 1) m_err = 1'b1;
                m_owner = -1;
                m_rr    = (sel + 1) % NR;
                m_beats = 0;
            end else begin
                if (m_beats + 1 == N_ROWS) m_err = 1'b1;
                m_beats++;
                m_owner = sel;
            end
            a_sent[sel]++;
            a_data[sel] = rnd_data();
            if (lst) a_active[sel] = 1'b0;
            ord_q.push_back(sel);
            cyc_q.push_back(cyc);
        end else if (sel >= 0) begin
            m_owner = sel;
        end
        for (int r = 0; r < NR; r++) begin
            if (a_bubble[r] > 0) a_bubble[r]--;
        end
        acc_idx  = acc ? sel : -1;
        acc_last = lst;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_idle(input int bound, input string nm);
        int n = 0;
        while (any_active() && n < bound) begin
            step();
            n++;
        end
        if (any_active()) begin
            checks++;
            failures++;
            $display("FAIL %s timeout after %0d cycles", nm, bound);
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_agents();
        drive();
        #1;
        quiet_checks("reset");
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        model_reset();
    endtask

    initial begin
        int hold;
        bit bd;
        bit rdy;
        clear_agents();
        drive();
        @(negedge clk);
        do_reset();

        // Single requester, full burst.
        start(1, 5, N_ROWS - 1);
        run_idle(20, "t1");
        check("t1_beats", ord_q.size(), 4);
        check("t1_cycles", cyc, 4);
        check("t1_owner", ord_q[3], 1);
        check("t1_rrptr", dut.rr_ptr_q, 2);
        check("t1_model_rr", m_rr, 2);
        check("t1_err", err_o, 0);

        // Contention with rotation at 1: req2 wins, req0 follows immediately.
        do_reset();
        start(0, 3, N_ROWS - 1);
        run_idle(20, "t2a");
        check("t2_rrptr", dut.rr_ptr_q, 1);
        cyc = 0;
        ord_q.delete();
        cyc_q.delete();
        start(0, 1, N_ROWS - 1);
        start(2, 2, N_ROWS - 1);
        run_idle(30, "t2b");
        check("t2_beats", ord_q.size(), 8);
        for (int i = 0; i < 4; i++) check("t2_first_owner", ord_q[i], 2);
        check("t2_first_end", cyc_q[3], 3);
        check("t2_second_owner", ord_q[4], 0);
        check("t2_second_start", cyc_q[4], 4);

        // Owner bubble of 3 cycles after row 1 while req1 waits.
        do_reset();
        start(0, 2, N_ROWS - 1);
        start(1, 7, N_ROWS - 1);
        bd = 1'b0;
        for (int n = 0; n < 30 && any_active(); n++) begin
            step();
            if (!bd && acc_idx == 0 && a_sent[0] == 2) begin
                a_bubble[0] = 3;
                bd = 1'b1;
            end
        end
        check("t3_beats", ord_q.size(), 8);
        for (int i = 0; i < 4; i++) check("t3_owner", ord_q[i], 0);
        check("t3_owner_end", cyc_q[3], 6);
        check("t3_next_owner", ord_q[4], 1);
        check("t3_next_start", cyc_q[4], 7);

        // Backpressure on row 2 for two cycles.
        do_reset();
        start(1, 3, N_ROWS - 1);
        hold = 0;
        for (int n = 0; n < 20 && any_active(); n++) begin
            rdy = !(a_sent[1] == 2 && hold < 2);
            ready_drv = rdy;
            step();
            if (!rdy) begin
                hold++;
                check("t4_beat_frozen", dut.beat_q, 2);
            end
        end
        ready_drv = 1'b1;
        check("t4_cycles", cyc, 6);
        check("t4_last_at", cyc_q[3], 5);

        // Early wlast on the second beat.
        do_reset();
        start(2, 4, 1);
        run_idle(10, "t5a");
        check("t5_err", err_o, 1);
        check("t5_unlocked", locked_o, 0);
        start(0, 0, N_ROWS - 1);
        run_idle(20, "t5b");
        check("t5_err_sticky", err_o, 1);

        // Reset after row 1, requests still present.
        start(1, 6, N_ROWS - 1);
        step();
        step();
        rst_ni = 1'b0;
        drive();
        #1;
        quiet_checks("t6");
        @(posedge clk);
        @(negedge clk);
        clear_agents();
        rst_ni = 1'b1;
        model_reset();
        start(1, 6, N_ROWS - 1);
        start(2, 1, N_ROWS - 1);
        run_idle(30, "t6");
        check("t6_beats", ord_q.size(), 8);
        check("t6_first_owner", ord_q[0], 1);
        check("t6_first_cycle", cyc_q[0], 0);

        // Randomized traffic, including odd burst lengths, bubbles and backpressure.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int r = 0; r < NR; r++) begin
                if (!a_active[r]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        start(r, int'($urandom_range(0, N_REGS - 1)),
                              ($urandom_range(0, 9) < 7) ? int'(N_ROWS - 1) : int'($urandom_range(0, 5)));
                    end
                end else if (a_sent[r] > 0 && a_bubble[r] == 0 && $urandom_range(0, 9) == 0) begin
                    a_bubble[r] = int'($urandom_range(1, 2));
                end
            end
            ready_drv = ($urandom_range(0, 4) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_rf_wport_arbiter.md
# matrix_rf_wport_arbiter

Round-robin, burst-locking arbiter sharing the single matrix register-file write port among N_REQ writer units (load unit, zero/permutation unit, systolic-array writeback). A grant is held from a requester's first write beat until its `wlast` beat is accepted, so one matrix register write sequence is never interleaved with another. It sits between the writer units and the register-file write port and forwards the port's `wready` only to the current owner.

## Interface
- `N_REQ`, 3, number of writer units (≥2)
- `RLEN`, 128, row width in bits
- `N_REGS`, 8, number of matrix registers
- `N_ROWS`, 4, rows per matrix register (≥2)
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `req_waddr_i`  in  N_REQ×$clog2(N_REGS)  per-requester destination register
- `req_wrowaddr_i`  in  N_REQ×$clog2(N_ROWS)  per-requester row address
- `req_wdata_i`  in  N_REQ×RLEN  per-requester row data
- `req_we_i`  in  N_REQ  per-requester write valid
- `req_wlast_i`  in  N_REQ  per-requester last beat of sequence
- `req_wready_o`  out  N_REQ  per-requester write accepted
- `waddr_o`, `wrowaddr_o`, `wdata_o`, `we_o`, `wlast_o`  out  as above  muxed register-file write port
- `wready_i`  in  1  register-file port ready
- `grant_o`  out  N_REQ  one-hot current owner (zero when none)
- `locked_o`  out  1  a burst is in progress
- `err_o`  out  1  sticky burst-length protocol error

## Operation
- States: IDLE, LOCKED. `owner_q` (index), `rr_ptr_q` (index), `beat_q` ($clog2(N_ROWS)+1 bits).
- IDLE: candidate = first requester with `req_we_i` set, searching from `rr_ptr_q` upward modulo N_REQ. Candidate granted combinationally the same cycle.
- Grant in IDLE, not a single-beat accepted `wlast`: go LOCKED, `owner_q` = candidate. Happens regardless of `wready_i`, so a presented beat never gets redirected.
- LOCKED: only `owner_q` is muxed through. `grant_o` stays on owner even if the owner drops `we` mid-burst. During such a bubble `we_o`=0 and the lock is kept.
- Accepted beat = `we_o & wready_i`. An accepted beat with `wlast_o` ends the burst:
  - return to IDLE;
  - `rr_ptr_q` = owner+1, wrapping N_REQ-1→0;
  - `beat_q` cleared.
- Non-owners: `req_wready_o`=0 always. Owner: `req_wready_o` = `wready_i`.
- No grant: all port outputs are 0.
- `beat_q` increments on each accepted non-last beat. `err_o` sets when either:
  - an accepted `wlast` has `beat_q` ≠ N_ROWS-1; or
  - a non-last accepted beat would make `beat_q` reach N_ROWS.
- `err_o` is cleared only by reset. Data is still forwarded unchanged when `err_o` is set.

## Timing
- Reset: state IDLE, `rr_ptr_q`=0, `owner_q`=0, `beat_q`=0. `grant_o`=0, `locked_o`=0, `err_o`=0, all port outputs 0, `req_wready_o`=0.
- Zero-cycle latency: request to port is purely combinational (mux plus picker). No registered data path.
- Back-to-back bursts: the cycle after an accepted `wlast`, IDLE arbitration picks the next requester. There is no dead cycle beyond that arbitration cycle.
- `wlast_o` and `we_o` may be high with `wready_i` low. The beat is held and retried, and the lock persists.
- Simultaneous requests in IDLE: `rr_ptr_q` priority only. A requester that keeps `we` asserted is granted within N_REQ bursts.
- Reset mid-burst: the lock is abandoned immediately. No partial state survives.

## Structure
- Shared package `matrix_pkg`:
  - `wport_beat_t` struct {waddr, wrowaddr, wdata, we, wlast}, parameterized widths via package constants RLEN/N_REGS/N_ROWS;
  - state enum `wport_arb_state_e`.
- Sub-module `matrix_rr_picker`: combinational, inputs request vector and pointer, outputs one-hot grant, index and valid.
- The arbiter owns the FSM, lock, pointer, beat counter and output mux.

## Test plan
- Single requester: req1 writes rows 0..3 to reg 5, `wready_i`=1. Expect 4 beats on port, `wlast_o` on row 3, `rr_ptr_q`→2, `err_o`=0.
- Contention: req0 and req2 assert `we` same cycle, `rr_ptr_q`=1. Expect req2 granted for all 4 beats, req0 `wready`=0 throughout, then req0 granted the next cycle.
- Owner bubble: req0 drops `we` for 3 cycles after row 1 while req1 requests. Expect lock held, `we_o`=0, req1 not granted until req0's `wlast` is accepted.
- Backpressure: `wready_i` low for 2 cycles on row 2. Expect port outputs stable, `beat_q` frozen, completion 2 cycles late.
- Protocol error: requester asserts `wlast` on its 2nd beat. Expect `err_o`=1, sticky, and release to IDLE.
- Reset mid-burst: assert `rst_ni`=0 after row 1. Expect all outputs 0 and `rr_ptr_q`=0 immediately; fresh arbitration after release.
